// File: rtl/warp_fetch_scheduler_if.sv
// Bundle between the warp scheduler and its neighbours: activity, redirects,
// IBuffer dequeues in; registered fetch grants and the credit error flag out.
interface warp_fetch_scheduler_if #(
    parameter int NUM_WARPS = 8
);
    logic                 Fetch_En;
    logic [NUM_WARPS-1:0] PC_Valid;
    logic [NUM_WARPS-1:0] UpdatePC_Qual1_SIMT_IF;
    logic [NUM_WARPS-1:0] UpdatePC_Qual2_SIMT_IF;
    logic [NUM_WARPS-1:0] UpdatePC_Qual3_ID0_IF;
    logic [NUM_WARPS-1:0] UpdatePC_Qual3_ID1_IF;
    logic [NUM_WARPS-1:0] Dequeue_IB_RR;
    logic [NUM_WARPS-1:0] GRT_raw_1_RR_IF;
    logic [NUM_WARPS-1:0] GRT_raw_2_RR_IF;
    logic                 Credit_Err;

    // Grants are not a valid/ready handshake: each is a single-cycle pulse that
    // fetch must consume in the cycle it is presented; backpressure is the credit.
    modport master (
        output Fetch_En, PC_Valid, UpdatePC_Qual1_SIMT_IF, UpdatePC_Qual2_SIMT_IF,
               UpdatePC_Qual3_ID0_IF, UpdatePC_Qual3_ID1_IF, Dequeue_IB_RR,
        input  GRT_raw_1_RR_IF, GRT_raw_2_RR_IF, Credit_Err
    );

    modport slave (
        input  Fetch_En, PC_Valid, UpdatePC_Qual1_SIMT_IF, UpdatePC_Qual2_SIMT_IF,
               UpdatePC_Qual3_ID0_IF, UpdatePC_Qual3_ID1_IF, Dequeue_IB_RR,
        output GRT_raw_1_RR_IF, GRT_raw_2_RR_IF, Credit_Err
    );
endinterface

// File: rtl/warp_fetch_scheduler.sv
// Dual-grant round-robin warp scheduler feeding instruction fetch, with
// per-warp IBuffer credit tracking so no grant can overrun a warp's IBuffer.
module warp_fetch_scheduler #(
    parameter int NUM_WARPS = 8,
    parameter int IB_DEPTH  = 4,
    parameter int CREDIT_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    warp_fetch_scheduler_if.slave   bus
);
    localparam int IDX_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(IB_DEPTH);

    logic [NUM_WARPS-1:0] gnt1_q, gnt1_d;
    logic [NUM_WARPS-1:0] gnt2_q, gnt2_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic                 err_q, err_d;
    logic [CREDIT_W-1:0]  credit_q [NUM_WARPS];
    logic [CREDIT_W-1:0]  credit_d [NUM_WARPS];

    logic [NUM_WARPS-1:0] flush;
    logic [NUM_WARPS-1:0] elig;
    logic [NUM_WARPS-1:0] granted;
    logic                 found1, found2;
    logic [IDX_W-1:0]     g1_idx, g2_idx, idx;

    always_comb begin
        flush = bus.UpdatePC_Qual1_SIMT_IF | bus.UpdatePC_Qual2_SIMT_IF |
                bus.UpdatePC_Qual3_ID0_IF  | bus.UpdatePC_Qual3_ID1_IF;
        for (int i = 0; i < NUM_WARPS; i++) begin
            elig[i] = bus.Fetch_En & bus.PC_Valid[i] & ~flush[i] & (credit_q[i] != '0);
        end
    end

    // Second scan starts just past grant 1 and stops before wrapping onto it.
    always_comb begin
        found1 = 1'b0;
        found2 = 1'b0;
        g1_idx = '0;
        g2_idx = '0;
        idx    = '0;
        for (int k = 0; k < NUM_WARPS; k++) begin
            idx = IDX_W'((int'(ptr_q) + k) % NUM_WARPS);
            if (!found1 && elig[idx]) begin
                found1 = 1'b1;
                g1_idx = idx;
            end
        end
        for (int k = 0; k < NUM_WARPS - 1; k++) begin
            idx = IDX_W'((int'(g1_idx) + 1 + k) % NUM_WARPS);
            if (found1 && !found2 && elig[idx]) begin
                found2 = 1'b1;
                g2_idx = idx;
            end
        end
    end

    always_comb begin
        gnt1_d  = found1 ? (NUM_WARPS'(1) << g1_idx) : '0;
        gnt2_d  = found2 ? (NUM_WARPS'(1) << g2_idx) : '0;
        granted = gnt1_d | gnt2_d;
        if (found2) begin
            ptr_d = IDX_W'((int'(g2_idx) + 1) % NUM_WARPS);
        end else if (found1) begin
            ptr_d = IDX_W'((int'(g1_idx) + 1) % NUM_WARPS);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Flush wins over everything; a lone dequeue at full credit saturates and flags.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < NUM_WARPS; i++) begin
            credit_d[i] = credit_q[i];
            if (flush[i]) begin
                credit_d[i] = CREDIT_FULL;
            end else if (granted[i] && !bus.Dequeue_IB_RR[i]) begin
                credit_d[i] = credit_q[i] - 1'b1;
            end else if (!granted[i] && bus.Dequeue_IB_RR[i]) begin
                if (credit_q[i] == CREDIT_FULL) begin
                    err_d = 1'b1;
                end else begin
                    credit_d[i] = credit_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt1_q <= '0;
            gnt2_q <= '0;
            ptr_q  <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < NUM_WARPS; i++) begin
                credit_q[i] <= CREDIT_FULL;
            end
        end else begin
            gnt1_q <= gnt1_d;
            gnt2_q <= gnt2_d;
            ptr_q  <= ptr_d;
            err_q  <= err_d;
            for (int i = 0; i < NUM_WARPS; i++) begin
                credit_q[i] <= credit_d[i];
            end
        end
    end

    assign bus.GRT_raw_1_RR_IF = gnt1_q;
    assign bus.GRT_raw_2_RR_IF = gnt2_q;
    assign bus.Credit_Err      = err_q;

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Directed bench for warp_fetch_scheduler: each driven cycle queues the
// hand-derived {Credit_Err, GRT1, GRT2} expected after the following edge.
module tb_warp_fetch_scheduler;
    localparam int W = 17;

    logic clk;
    logic rst;
    logic fetch_en;
    int   checks;
    int   failures;
    logic [W-1:0] exp_q[$];

    warp_fetch_scheduler_if #(.NUM_WARPS(8)) bus ();

    warp_fetch_scheduler #(
        .NUM_WARPS(8),
        .IB_DEPTH (4),
        .CREDIT_W (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] observed();
        return {bus.Credit_Err, bus.GRT_raw_1_RR_IF, bus.GRT_raw_2_RR_IF};
    endfunction

    // driver tasks
    task automatic drive_idle();
        bus.Fetch_En               = 1'b0;
        bus.PC_Valid               = '0;
        bus.UpdatePC_Qual1_SIMT_IF = '0;
        bus.UpdatePC_Qual2_SIMT_IF = '0;
        bus.UpdatePC_Qual3_ID0_IF  = '0;
        bus.UpdatePC_Qual3_ID1_IF  = '0;
        bus.Dequeue_IB_RR          = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state", observed(), '0);
        rst = 1'b0;
    endtask

    // One cycle of stimulus; sel picks which redirect input carries the flush.
    task automatic step(input logic [7:0] valid, input logic [7:0] deq,
                        input logic [7:0] fl, input logic [1:0] sel,
                        input logic [7:0] e1, input logic [7:0] e2, input logic eerr);
        @(negedge clk);
        bus.Fetch_En               = fetch_en;
        bus.PC_Valid               = valid;
        bus.Dequeue_IB_RR          = deq;
        bus.UpdatePC_Qual1_SIMT_IF = (sel == 2'd0) ? fl : 8'h00;
        bus.UpdatePC_Qual2_SIMT_IF = (sel == 2'd1) ? fl : 8'h00;
        bus.UpdatePC_Qual3_ID0_IF  = (sel == 2'd2) ? fl : 8'h00;
        bus.UpdatePC_Qual3_ID1_IF  = (sel == 2'd3) ? fl : 8'h00;
        exp_q.push_back({eerr, e1, e2});
    endtask

    // scoreboard monitor
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            chk("grant_seq", observed(), e);
        end
    end

    logic [7:0] pair1 [4];
    logic [7:0] pair2 [4];

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        fetch_en = 1'b1;
        drive_idle();
        pair1 = '{8'h01, 8'h04, 8'h10, 8'h40};
        pair2 = '{8'h02, 8'h08, 8'h20, 8'h80};

        // All warps valid: pairs rotate until every warp used its 4 credits
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < 4; p++) begin
                step(8'hFF, 8'h00, 8'h00, 2'd0, pair1[p], pair2[p], 1'b0);
            end
        end
        step(8'hFF, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 1'b0);
        step(8'hFF, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 1'b0);

        // Single warp 5
        do_reset();
        repeat (4) step(8'h20, 8'h00, 8'h00, 2'd0, 8'h20, 8'h00, 1'b0);
        step(8'h20, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 1'b0);

        // Warp 2 drained, then one dequeue -> grant two cycles later
        do_reset();
        repeat (4) step(8'h04, 8'h00, 8'h00, 2'd0, 8'h04, 8'h00, 1'b0);
        step(8'h04, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 1'b0);
        step(8'h04, 8'h04, 8'h00, 2'd0, 8'h00, 8'h00, 1'b0);
        step(8'h04, 8'h00, 8'h00, 2'd0, 8'h04, 8'h00, 1'b0);
        step(8'h04, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 1'b0);

        // Grant 2 wraps past warp 7 back to warp 0
        do_reset();
        step(8'h81, 8'h00, 8'h00, 2'd0, 8'h01, 8'h80, 1'b0);
        step(8'h81, 8'h00, 8'h00, 2'd0, 8'h01, 8'h80, 1'b0);

        // Three sparse warps: pointer advances past grant 2
        do_reset();
        step(8'h2A, 8'h00, 8'h00, 2'd0, 8'h02, 8'h08, 1'b0);
        step(8'h2A, 8'h00, 8'h00, 2'd0, 8'h20, 8'h02, 1'b0);
        step(8'h2A, 8'h00, 8'h00, 2'd0, 8'h08, 8'h20, 1'b0);
        step(8'h2A, 8'h00, 8'h00, 2'd0, 8'h02, 8'h08, 1'b0);

        // Fetch disabled: no grants, pointer holds
        do_reset();
        fetch_en = 1'b0;
        step(8'hFF, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 1'b0);
        step(8'hFF, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 1'b0);
        fetch_en = 1'b1;
        step(8'hFF, 8'h00, 8'h00, 2'd0, 8'h01, 8'h02, 1'b0);

        // Flush through each redirect input masks eligibility
        do_reset();
        step(8'h0F, 8'h00, 8'h01, 2'd0, 8'h02, 8'h04, 1'b0);
        step(8'h0F, 8'h00, 8'h02, 2'd1, 8'h08, 8'h01, 1'b0);
        step(8'h0F, 8'h00, 8'h04, 2'd2, 8'h02, 8'h08, 1'b0);

        // Flush warp 3 with dequeue: credit restored to 4, not 3
        do_reset();
        step(8'h08, 8'h00, 8'h00, 2'd0, 8'h08, 8'h00, 1'b0);
        step(8'h08, 8'h00, 8'h00, 2'd0, 8'h08, 8'h00, 1'b0);
        step(8'h08, 8'h08, 8'h08, 2'd3, 8'h00, 8'h00, 1'b0);
        repeat (4) step(8'h08, 8'h00, 8'h00, 2'd0, 8'h08, 8'h00, 1'b0);
        step(8'h08, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 1'b0);

        // Grant+dequeue at full credit is fine; lone dequeue at full sets sticky error
        do_reset();
        step(8'h01, 8'h01, 8'h00, 2'd0, 8'h01, 8'h00, 1'b0);
        step(8'h00, 8'h01, 8'h00, 2'd0, 8'h00, 8'h00, 1'b1);
        step(8'h00, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 1'b1);
        repeat (4) step(8'h01, 8'h00, 8'h00, 2'd0, 8'h01, 8'h00, 1'b1);
        step(8'h01, 8'h00, 8'h00, 2'd0, 8'h00, 8'h00, 1'b1);

        // Asynchronous reset clears live grants and the sticky error mid-cycle
        step(8'hFE, 8'h00, 8'h00, 2'd0, 8'h02, 8'h04, 1'b1);
        @(posedge clk);
        #3;
        chk("pre_async_rst", observed(), {1'b1, 8'h02, 8'h04});
        rst = 1'b1;
        #1;
        chk("async_rst", observed(), '0);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        rst = 1'b0;

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
